// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i core: pipeline controller state encoding.
package rv32i_pkg;

    typedef enum logic [2:0] {
        PC_RUN,
        PC_MEM_WAIT,
        PC_FLUSH,
        PC_DRAIN,
        PC_HALTED
    } pctrl_state_t;

    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the F/D/X core: stall, flush, forward, halt and perf counters.
// Outputs are combinational from state and this cycle's inputs so forwarding and stalls act with zero latency.
module pipeline_ctrl
    import rv32i_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_use_rs1,
    input  logic                  d_use_rs2,
    input  logic                  d_system,
    input  logic                  x_valid,
    input  logic [REG_ADDR_W-1:0] x_rd,
    input  logic                  x_reg_write,
    input  logic                  x_mem_read,
    input  logic                  x_mem_op,
    input  logic                  dmem_ready,
    input  logic                  x_redirect,
    output logic                  f_stall,
    output logic                  d_stall,
    output logic                  d_bubble,
    output logic                  fd_flush,
    output logic                  fwd_rs1,
    output logic                  fwd_rs2,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);

    pctrl_state_t  state, state_n;
    logic [CW-1:0] count, count_n;
    logic          hit_rs1, hit_rs2;
    logic          mem_wait;

    assign hit_rs1 = x_valid && x_reg_write && (x_rd == d_rs1) && (d_rs1 != '0) && d_use_rs1 && d_valid;
    assign hit_rs2 = x_valid && x_reg_write && (x_rd == d_rs2) && (d_rs2 != '0) && d_use_rs2 && d_valid;
    assign mem_wait = x_valid && x_mem_op && !dmem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PC_RUN;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        fd_flush = 1'b0;
        halted   = 1'b0;
        fwd_rs1  = 1'b0;
        fwd_rs2  = 1'b0;
        if (!rst) begin
            unique case (state)
                // MEM_WAIT with dmem_ready falls through to the ordinary RUN rules in the same cycle.
                PC_RUN, PC_MEM_WAIT: begin
                    if (mem_wait) begin
                        f_stall = 1'b1;
                        d_stall = 1'b1;
                        state_n = PC_MEM_WAIT;
                    end else if (x_redirect) begin
                        fd_flush = 1'b1;
                        d_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = PC_FLUSH;
                            count_n = FLUSH_RELOAD;
                        end else begin
                            state_n = PC_RUN;
                        end
                    end else if (d_system && d_valid) begin
                        f_stall  = 1'b1;
                        d_bubble = 1'b1;
                        state_n  = PC_DRAIN;
                    end else begin
                        state_n = PC_RUN;
                    end
                end
                PC_FLUSH: begin
                    fd_flush = 1'b1;
                    d_bubble = 1'b1;
                    if (x_redirect) begin
                        count_n = FLUSH_RELOAD;
                    end else begin
                        count_n = count - 1'b1;
                        if (count <= CW'(1)) begin
                            state_n = PC_RUN;
                        end
                    end
                end
                // An older branch still in X outranks the pending halt.
                PC_DRAIN: begin
                    if (x_redirect) begin
                        fd_flush = 1'b1;
                        d_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = PC_FLUSH;
                            count_n = FLUSH_RELOAD;
                        end else begin
                            state_n = PC_RUN;
                        end
                    end else begin
                        f_stall  = 1'b1;
                        d_bubble = 1'b1;
                        if (!x_valid || (x_mem_op && dmem_ready)) begin
                            state_n = PC_HALTED;
                        end
                    end
                end
                PC_HALTED: begin
                    halted   = 1'b1;
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    d_bubble = 1'b1;
                end
                default: begin
                    state_n = PC_RUN;
                end
            endcase
            fwd_rs1 = hit_rs1 && !d_bubble && (state != PC_HALTED);
            fwd_rs2 = hit_rs2 && !d_bubble && (state != PC_HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (f_stall),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .en  (fd_flush),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with FLUSH_CYCLES=2 and a 4-bit counter so saturation is reachable.
module tb_pipeline_ctrl;
    import rv32i_pkg::*;

    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid, d_use_rs1, d_use_rs2, d_system;
    logic [4:0]    d_rs1, d_rs2, x_rd;
    logic          x_valid, x_reg_write, x_mem_read, x_mem_op, dmem_ready, x_redirect;
    logic          f_stall, d_stall, d_bubble, fd_flush, fwd_rs1, fwd_rs2, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_system(d_system),
        .x_valid(x_valid), .x_rd(x_rd), .x_reg_write(x_reg_write),
        .x_mem_read(x_mem_read), .x_mem_op(x_mem_op), .dmem_ready(dmem_ready),
        .x_redirect(x_redirect),
        .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .fd_flush(fd_flush),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0; d_system = 0;
        x_valid = 0; x_rd = 0; x_reg_write = 0; x_mem_read = 0; x_mem_op = 0;
        dmem_ready = 0; x_redirect = 0;
    endtask

    initial begin
        int exp_stall;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        settle();
        chk("rst_f_stall", f_stall, 0);
        chk("rst_d_stall", d_stall, 0);
        chk("rst_d_bubble", d_bubble, 0);
        chk("rst_fd_flush", fd_flush, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        // ALU result forwarded to rs1; rs2 names same reg but is unused
        x_valid = 1; x_rd = 5; x_reg_write = 1;
        d_valid = 1; d_rs1 = 5; d_use_rs1 = 1; d_rs2 = 5; d_use_rs2 = 0;
        settle();
        chk("alu_fwd_rs1", fwd_rs1, 1);
        chk("alu_fwd_rs2_unused", fwd_rs2, 0);
        chk("alu_f_stall", f_stall, 0);
        tick();
        chk("alu_stall_cnt", stall_cnt, 0);

        x_rd = 0; d_rs1 = 0;
        settle();
        chk("x0_no_fwd", fwd_rs1, 0);
        tick();

        // load-use with memory stalling three cycles
        idle_inputs();
        x_valid = 1; x_rd = 6; x_reg_write = 1; x_mem_read = 1; x_mem_op = 1; dmem_ready = 0;
        d_valid = 1; d_rs2 = 6; d_use_rs2 = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ld_wait_f_stall", f_stall, 1);
            chk("ld_wait_d_stall", d_stall, 1);
            chk("ld_wait_bubble", d_bubble, 0);
            tick();
        end
        dmem_ready = 1;
        settle();
        chk("ld_done_fwd_rs2", fwd_rs2, 1);
        chk("ld_done_f_stall", f_stall, 0);
        chk("ld_done_d_stall", d_stall, 0);
        chk("ld_stall_cnt", stall_cnt, 3);
        tick();
        idle_inputs();
        settle();
        chk("ld_stall_cnt_hold", stall_cnt, 3);

        // redirect, with a would-be forward suppressed by the bubble
        x_valid = 1; x_redirect = 1; x_rd = 7; x_reg_write = 1;
        d_valid = 1; d_rs1 = 7; d_use_rs1 = 1;
        settle();
        chk("redir_fd_flush", fd_flush, 1);
        chk("redir_bubble", d_bubble, 1);
        chk("redir_f_stall", f_stall, 0);
        chk("redir_fwd_masked", fwd_rs1, 0);
        tick();
        idle_inputs();
        settle();
        chk("flush2_fd_flush", fd_flush, 1);
        chk("flush2_bubble", d_bubble, 1);
        tick();
        settle();
        chk("flush_end_fd_flush", fd_flush, 0);
        chk("flush_end_bubble", d_bubble, 0);
        chk("flush_cnt_2", flush_cnt, 2);

        // system and redirect together: redirect wins, no halt
        x_valid = 1; x_redirect = 1; d_valid = 1; d_system = 1;
        settle();
        chk("sysredir_fd_flush", fd_flush, 1);
        chk("sysredir_f_stall", f_stall, 0);
        tick();
        idle_inputs();
        settle();
        chk("sysredir_halted", halted, 0);
        chk("sysredir_flush2", fd_flush, 1);
        tick();
        settle();
        chk("sysredir_run", fd_flush, 0);
        chk("sysredir_halted2", halted, 0);
        chk("flush_cnt_4", flush_cnt, 4);

        // system behind a store that waits two cycles
        d_valid = 1; d_system = 1; x_valid = 1; x_mem_op = 1; dmem_ready = 0;
        settle();
        chk("sys_mw_f_stall", f_stall, 1);
        chk("sys_mw_d_stall", d_stall, 1);
        tick();
        settle();
        chk("sys_mw2_d_stall", d_stall, 1);
        tick();
        dmem_ready = 1;
        settle();
        chk("sys_issue_f_stall", f_stall, 1);
        chk("sys_issue_d_stall", d_stall, 0);
        chk("sys_issue_bubble", d_bubble, 1);
        chk("sys_issue_halted", halted, 0);
        tick();
        x_valid = 0; x_mem_op = 0; dmem_ready = 0;
        settle();
        chk("drain_f_stall", f_stall, 1);
        chk("drain_bubble", d_bubble, 1);
        chk("drain_halted", halted, 0);
        tick();
        settle();
        chk("halt_halted", halted, 1);
        chk("halt_d_stall", d_stall, 1);
        chk("halt_fd_flush", fd_flush, 0);
        chk("halt_stall_cnt", stall_cnt, 7);
        exp_stall = 7;
        x_valid = 1; x_redirect = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
            settle();
            chk("halt_hold", halted, 1);
            chk("halt_no_flush", fd_flush, 0);
            chk("halt_stall_sat", stall_cnt, exp_stall);
        end
        chk("stall_cnt_max", stall_cnt, 15);
        chk("halt_flush_cnt", flush_cnt, 4);

        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        settle();
        chk("post_rst_halted", halted, 0);
        chk("post_rst_f_stall", f_stall, 0);
        chk("post_rst_stall_cnt", stall_cnt, 0);
        chk("post_rst_flush_cnt", flush_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
